// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and constants for the router output arbiter.
//                Flit layout (32-bit): {dest[31:30], deltas[29:28], payload}.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Output arbiter FSM states
    typedef enum logic {
        ARB_IDLE     = 1'b0,
        ARB_WAIT_ACK = 1'b1
    } arb_state_t;

    // Flit field positions
    localparam int FLIT_W         = 32;
    localparam int FLIT_DEST_MSB  = FLIT_W - 1;
    localparam int FLIT_DEST_LSB  = FLIT_W - 2;
    localparam int FLIT_DELTA_MSB = FLIT_W - 3;
    localparam int FLIT_DELTA_LSB = FLIT_W - 4;

    // Default number of requesters sharing one output
    localparam int DEFAULT_NPORTS = 4;

endpackage : router_pkg
`default_nettype wire

// File: rtl/rt_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rt_rr_pick
//  Description : Combinational round-robin picker. Searches pend starting at
//                ptr+1 and wrapping modulo NPORTS; the first set bit wins.
//  Ports       : pend  [NPORTS]  - pending request vector
//                ptr   [PTR_W]   - index of the previous winner
//                g     [PTR_W]   - selected winner (0 when nothing pending)
//                valid           - at least one bit of pend is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rt_rr_pick #(
    parameter int NPORTS = 4,
    parameter int PTR_W  = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] pend,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  g,
    output logic              valid
);

    always_comb begin
        int w_idx;
        g     = '0;
        valid = 1'b0;
        w_idx = 0;
        // k = NPORTS revisits ptr itself last, so a lone requester that just
        // won is still picked again immediately.
        for (int k = 1; k <= NPORTS; k++) begin
            w_idx = (int'(ptr) + k) % NPORTS;
            if (!valid && pend[w_idx]) begin
                valid = 1'b1;
                g     = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule : rt_rr_pick
`default_nettype wire

// File: rtl/rt_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rt_output_arbiter
//  Description : Shares one two-phase (toggle) req/ack output channel among
//                NPORTS requesters with round-robin priority. The granted flit
//                is registered onto out_data; the winner's in_ack toggles only
//                after the downstream out_ack has caught up with out_req.
//  Ports       : clk, rst (async, active-low)
//                in_req[NPORTS], in_ack[NPORTS], in_data[NPORTS*N]
//                out_req, out_ack, out_data[N]
//                grant_idx[$clog2(NPORTS)] - current / last winner
//                busy - high while waiting for the downstream ack
//  Options     : RT_ARB_SYNC_INPUTS_EN - pass in_req and out_ack through
//                2-flop synchronizers (adds 2 cycles to each handshake leg).
//  Revision    : 1.0 - initial release
// ============================================================================
module rt_output_arbiter
    import router_pkg::*;
#(
    parameter int N      = FLIT_W,
    parameter int NPORTS = DEFAULT_NPORTS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS-1:0]          in_req,
    output logic [NPORTS-1:0]          in_ack,
    input  logic [NPORTS*N-1:0]        in_data,
    output logic                       out_req,
    input  logic                       out_ack,
    output logic [N-1:0]               out_data,
    output logic [$clog2(NPORTS)-1:0]  grant_idx,
    output logic                       busy
);

    localparam int PTR_W = $clog2(NPORTS);

    logic [NPORTS-1:0] w_in_req;
    logic              w_out_ack;

`ifdef RT_ARB_SYNC_INPUTS_EN
    logic [NPORTS-1:0] r_req_s1, r_req_s2;
    logic              r_ack_s1, r_ack_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_s1 <= '0;
            r_req_s2 <= '0;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_req_s1 <= in_req;
            r_req_s2 <= r_req_s1;
            r_ack_s1 <= out_ack;
            r_ack_s2 <= r_ack_s1;
        end
    end

    assign w_in_req  = r_req_s2;
    assign w_out_ack = r_ack_s2;
`else
    assign w_in_req  = in_req;
    assign w_out_ack = out_ack;
`endif

    arb_state_t        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [NPORTS-1:0] r_in_ack;
    logic              r_out_req;
    logic [N-1:0]      r_out_data;
    logic [PTR_W-1:0]  r_grant;
    logic              r_busy;

    logic [NPORTS-1:0] w_pend;
    logic [PTR_W-1:0]  w_g;
    logic              w_valid;

    // A request is outstanding while its two toggles disagree.
    assign w_pend = w_in_req ^ r_in_ack;

    rt_rr_pick #(
        .NPORTS (NPORTS),
        .PTR_W  (PTR_W)
    ) u_pick (
        .pend  (w_pend),
        .ptr   (r_ptr),
        .g     (w_g),
        .valid (w_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= PTR_W'(NPORTS - 1);   // input 0 gets first priority
            r_in_ack   <= '0;
            r_out_req  <= 1'b0;
            r_out_data <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_out_data <= in_data[int'(w_g)*N +: N];
                        r_out_req  <= ~r_out_req;
                        r_grant    <= w_g;
                        r_ptr      <= w_g;
                        r_busy     <= 1'b1;
                        r_state    <= ARB_WAIT_ACK;
                    end
                end
                ARB_WAIT_ACK: begin
                    // Downstream has consumed the flit once its ack matches.
                    if (w_out_ack == r_out_req) begin
                        r_in_ack[r_grant] <= ~r_in_ack[r_grant];
                        r_busy            <= 1'b0;
                        r_state           <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign in_ack    = r_in_ack;
    assign out_req   = r_out_req;
    assign out_data  = r_out_data;
    assign grant_idx = r_grant;
    assign busy      = r_busy;

endmodule : rt_output_arbiter
`default_nettype wire

// File: tb/tb_rt_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rt_output_arbiter
//  Description : Self-checking bench for rt_output_arbiter. Acts as the
//                requesters and the downstream consumer; expectations come
//                from a round-robin distance model kept in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rt_output_arbiter;

    localparam int N      = 32;
    localparam int NPORTS = 4;
    localparam int PW     = $clog2(NPORTS);
`ifdef RT_ARB_SYNC_INPUTS_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic                clk;
    logic                rst;
    logic [NPORTS-1:0]   in_req;
    logic [NPORTS-1:0]   in_ack;
    logic [NPORTS*N-1:0] in_data;
    logic                out_req;
    logic                out_ack;
    logic [N-1:0]        out_data;
    logic [PW-1:0]       grant_idx;
    logic                busy;

    rt_output_arbiter #(.N(N), .NPORTS(NPORTS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .out_data  (out_data),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NPORTS-1:0] m_req;
    logic [NPORTS-1:0] m_ack;
    logic [N-1:0]      m_flit [NPORTS];
    int                m_last;
    int                m_gidx;
    logic              m_outreq;
    int                order_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ack    = '0;
        m_last   = NPORTS - 1;
        m_gidx   = 0;
        m_outreq = 1'b0;
    endtask

    // Winner = pending input with the smallest forward distance past the last winner.
    function automatic int model_pick();
        int best  = -1;
        int bestd = NPORTS + 1;
        for (int i = 0; i < NPORTS; i++) begin
            if (m_req[i] != m_ack[i]) begin
                int d = (i - m_last - 1 + 2 * NPORTS) % NPORTS;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic raise(input int i, input logic [N-1:0] flit);
        m_flit[i]          = flit;
        in_data[i*N +: N]  = flit;
        m_req[i]           = ~m_req[i];
        in_req             = m_req;
    endtask

    // Serve one transaction: pre idle cycles, grant, hold, downstream ack.
    task automatic serve_one(input int pre, input int hold);
        int gi;
        gi = model_pick();
        if (gi < 0) return;
        for (int p = 0; p < pre; p++) begin
            tick();
            checks++;
            if (out_req !== m_outreq || busy !== 1'b0 || grant_idx !== PW'(m_gidx)) begin
                errors++;
                $display("FAIL early_grant: out_req=%b busy=%b grant_idx=%0d required out_req=%b busy=0 grant_idx=%0d",
                         out_req, busy, grant_idx, m_outreq, m_gidx);
            end
        end
        tick();
        m_outreq = ~m_outreq;
        m_gidx   = gi;
        checks++;
        if (out_req !== m_outreq || out_data !== m_flit[gi] || grant_idx !== PW'(gi) || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant: out_req=%b out_data=%h grant_idx=%0d busy=%b required %b %h %0d 1",
                     out_req, out_data, grant_idx, busy, m_outreq, m_flit[gi], gi);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (out_req !== m_outreq || out_data !== m_flit[gi] || busy !== 1'b1 || in_ack !== m_ack) begin
                errors++;
                $display("FAIL hold_stable: out_req=%b out_data=%h busy=%b in_ack=%b required %b %h 1 %b",
                         out_req, out_data, busy, in_ack, m_outreq, m_flit[gi], m_ack);
            end
        end
        out_ack = m_outreq;
        for (int p = 0; p < SYNC_LAT; p++) begin
            tick();
            checks++;
            if (in_ack !== m_ack || busy !== 1'b1) begin
                errors++;
                $display("FAIL early_ack: in_ack=%b busy=%b required %b 1", in_ack, busy, m_ack);
            end
        end
        tick();
        m_ack[gi] = ~m_ack[gi];
        checks++;
        if (in_ack !== m_ack || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_return: in_ack=%b busy=%b required %b 0", in_ack, busy, m_ack);
        end
        m_last = gi;
        order_q.push_back(gi);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_req !== 1'b0 || in_ack !== '0 || out_data !== '0 || grant_idx !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_req=%b in_ack=%b out_data=%h grant_idx=%0d busy=%b required all zero",
                     out_req, in_ack, out_data, grant_idx, busy);
        end
        rst = 1'b1;
        model_reset();
        repeat (SYNC_LAT + 2) tick();
        checks++;
        if (out_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: out_req=%b busy=%b required 0 0", out_req, busy);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] fl [NPORTS];
        logic [NPORTS-1:0] ack0;
        fl[0] = 32'h0EEEEEEE; fl[1] = 32'h0DDDDDDD; fl[2] = 32'h0CCCCCCC; fl[3] = 32'h0AAAAAAA;
        order_q.delete();
        ack0 = m_ack;
        for (int i = 0; i < NPORTS; i++) raise(i, fl[i]);
        serve_one(SYNC_LAT, 1);
        for (int i = 1; i < NPORTS; i++) serve_one(0, 1);
        for (int i = 0; i < NPORTS; i++) begin
            checks++;
            if (order_q.size() <= i || order_q[i] != i) begin
                errors++;
                $display("FAIL rr_order: slot %0d got %0d required %0d", i,
                         (order_q.size() > i) ? order_q[i] : -1, i);
            end
        end
        checks++;
        if (in_ack !== ~ack0) begin
            errors++;
            $display("FAIL rr_one_ack_each: in_ack=%b required %b", in_ack, ~ack0);
        end
    endtask

    task automatic test_wrap();
        order_q.delete();
        raise(0, 32'h11112222);
        raise(3, 32'h33334444);
        serve_one(SYNC_LAT, 0);
        serve_one(0, 0);
        checks++;
        if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 3) begin
            errors++;
            $display("FAIL wrap_order: got %0d,%0d required 0,3",
                     (order_q.size() > 0) ? order_q[0] : -1, (order_q.size() > 1) ? order_q[1] : -1);
        end
    endtask

    task automatic test_single();
        raise(1, 32'h6FFFFFFF);
        serve_one(SYNC_LAT, 0);
        checks++;
        if (grant_idx !== PW'(1) || out_data !== 32'h6FFFFFFF) begin
            errors++;
            $display("FAIL single_idx: grant_idx=%0d out_data=%h required 1 6fffffff", grant_idx, out_data);
        end
        // Lone requester is re-granted straight away despite ptr pointing at it.
        raise(1, 32'h5A5A0001);
        serve_one(SYNC_LAT, 0);
    endtask

    task automatic test_slow_ack();
        raise(2, 32'hC0FFEE42);
        serve_one(SYNC_LAT, 20);
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            logic [NPORTS-1:0] mask;
            int first;
            mask = NPORTS'($urandom_range(0, (1 << NPORTS) - 1));
            for (int i = 0; i < NPORTS; i++)
                if (mask[i]) raise(i, N'($urandom()));
            if (mask == '0) begin
                repeat (SYNC_LAT + 1) tick();
                checks++;
                if (out_req !== m_outreq || busy !== 1'b0 || in_ack !== m_ack) begin
                    errors++;
                    $display("FAIL rand_idle: out_req=%b busy=%b in_ack=%b required %b 0 %b",
                             out_req, busy, in_ack, m_outreq, m_ack);
                end
            end else begin
                first = 1;
                while (model_pick() >= 0) begin
                    serve_one(first ? SYNC_LAT : 0, $urandom_range(0, 3));
                    first = 0;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        // Clean start with no requests asserted.
        rst = 1'b0; in_req = '0; m_req = '0; out_ack = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        tick();
        raise(0, 32'h9ABCDEF0);
        repeat (SYNC_LAT + 1) tick();
        checks++;
        if (busy !== 1'b1 || out_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: busy=%b out_req=%b required 1 1", busy, out_req);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (out_req !== 1'b0 || in_ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out_req=%b in_ack=%b busy=%b required 0 0 0", out_req, in_ack, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        out_ack = 1'b0;
        serve_one(SYNC_LAT, 0);
        checks++;
        if (order_q.size() == 0 || order_q[$] != 0) begin
            errors++;
            $display("FAIL regrant_after_reset: last winner %0d required 0",
                     (order_q.size() > 0) ? order_q[$] : -1);
        end
    endtask

    initial begin
        rst     = 1'b0;
        in_req  = '0;
        in_data = '0;
        out_ack = 1'b0;
        m_req   = '0;
        for (int i = 0; i < NPORTS; i++) m_flit[i] = '0;
        model_reset();

        test_reset();
        test_fairness();
        test_wrap();
        test_single();
        test_slow_ack();
        test_random();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rt_output_arbiter
`default_nettype wire
